if_id_reg: RTL
==============

Name: if_id_reg

Overview:
- Fetch-to-decode pipeline register of the pipelined MIPS core.
- Sits directly downstream of the PC register. It captures the current PC and the instruction-memory word for that PC, and presents them to the decode stage.
- Adds the following to each captured instruction:
  - a valid bit
  - fetch-address exception tagging (AdEL)
  - a branch-delay-slot flag for CP0
  - PC+8 for link instructions
- Honours the same stall signal that freezes the PC register, plus a flush used on exception/eret.

Parameters:
- PC_RESET, 32'h0000_3000, PC value presented in D after reset; matches the PC register reset value.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, ExcCode for an illegal fetch address.

Ports:
- IFID_clk_i  input  1  clock; all state updates on posedge.
- IFID_reset_n_i  input  1  synchronous, active-low reset.
- IFID_pc_i  input  32  PC of the instruction being fetched (PC register output).
- IFID_instr_i  input  32  instruction-memory read data for IFID_pc_i; combinational memory.
- IFID_stall_i  input  1  hold D contents; driven by the same hazard signal as the PC register stall.
- IFID_flush_i  input  1  replace D contents with a bubble.
- IFID_instr_o  output  32  instruction in D.
- IFID_pc_o  output  32  PC of the instruction in D.
- IFID_pc8_o  output  32  IFID_pc_o + 8.
- IFID_exc_o  output  5  ExcCode of the D instruction; 0 means none.
- IFID_bd_o  output  1  the D instruction sits in a branch delay slot.
- IFID_valid_o  output  1  D holds a real instruction, not a bubble.

Behaviour:
- Update priority each posedge: reset > flush > stall > load.
- Reset (IFID_reset_n_i == 0 at posedge):
  - instr_o = 0, pc_o = PC_RESET, pc8_o = PC_RESET + 8.
  - exc_o = 0, bd_o = 0, valid_o = 0.
- Flush (overrides stall when both are asserted):
  - instr_o = 0 (sll nop), exc_o = 0, bd_o = 0, valid_o = 0.
  - pc_o/pc8_o load from IFID_pc_i, so a bubble carries a meaningful PC for CP0.
- Stall: every output register holds its value.
- Load:
  - pc_o <= IFID_pc_i and pc8_o <= IFID_pc_i + 8; the adder wraps modulo 2^32.
  - valid_o <= 1.
  - Address check: if IFID_pc_i[1:0] != 0, or IFID_pc_i < IM_BASE, or IFID_pc_i > IM_LIMIT:
    - exc_o <= EXC_ADEL and instr_o <= 0, so the faulting fetch never decodes as an instruction.
    - valid_o stays 1, so the exception propagates.
  - Otherwise exc_o <= 0 and instr_o <= IFID_instr_i.
  - bd_o <= valid_o & is_branch_jump(current instr_o). This is evaluated on the instruction being replaced, i.e. its predecessor in program order.
- is_branch_jump decode:
  - opcode 000001 (regimm), 000010 (j), 000011 (jal), 000100 (beq), 000101 (bne), 000110 (blez), 000111 (bgtz);
  - or opcode 000000 with funct 001000 (jr) or 001001 (jalr).
- A bubble (valid_o = 0) in D never marks its successor as a delay slot.
- A fetch tagged AdEL has instr_o = 0, so it never marks its successor either.
- Latency: one cycle from IFID_pc_i/IFID_instr_i to the outputs. There are no combinational paths from input to output.
- Reset asserted during a stall or flush: reset wins. Release of reset is the next load.

Decomposition:
- Shared package contents:
  - opcode/funct constants (OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_SPECIAL, FN_JR, FN_JALR);
  - ExcCode constants (EXC_NONE = 0, EXC_ADEL = 4);
  - PC_RESET.
- Sub-module: branch_jump_detect, combinational, 32-bit instr in, 1-bit out. The decode stage reuses it.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with pc_i = 0x3010 → instr_o = 0, pc_o = 0x3000, pc8_o = 0x3008, valid_o = 0, bd_o = 0, exc_o = 0.
- Normal load: pc_i = 0x3000 with instr_i = 0x3C011234 (lui), then pc_i = 0x3004 with instr_i = 0x00000000 → after the first posedge instr_o = 0x3C011234, pc8_o = 0x3008, valid_o = 1, bd_o = 0; after the second, pc_o = 0x3004 and bd_o = 0.
- Delay slot: load beq 0x10220003 at 0x3008, then addu 0x00221821 at 0x300C → the second load has bd_o = 1. Repeat with jr 0x03E00008 then addu → bd_o = 1.
- Stall: assert stall for 3 cycles while pc_i/instr_i change → all outputs frozen. Deassert → the next posedge loads the current inputs.
- Flush vs stall: stall = 1 and flush = 1 together with pc_i = 0x3020 → instr_o = 0, valid_o = 0, pc_o = 0x3020. The next load after a bubble following a beq gives bd_o = 0.
- AdEL: pc_i = 0x3002 and instr_i = 0xFFFFFFFF → exc_o = 4, instr_o = 0, valid_o = 1. The same result for pc_i = 0x7000 and for 0x2FFC. pc_i = 0x6FFC → exc_o = 0.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// ---------------------------------------------------------------------------
// if_id_reg_pkg
// Shared constants for the fetch/decode boundary of the pipelined MIPS core:
// the opcode and funct values that identify control-transfer instructions,
// the ExcCode values raised at fetch, and the reset/legal-range PC values.
// The helper functions pull the opcode and funct fields out of an
// instruction word, so every user slices the word the same way.
// ---------------------------------------------------------------------------
package if_id_reg_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL funct codes (instr[5:0]) for register jumps
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // CP0 ExcCode values raised by the fetch stage
    localparam logic [4:0] EXC_NONE   = 5'd0;
    localparam logic [4:0] EXC_ADEL   = 5'd4;

    // PC register reset value and the legal instruction-memory window
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFC;

    // Return address for link instructions skips the delay slot
    localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

    function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] functOf(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/if_id_reg_branch_jump_detect.sv
// ---------------------------------------------------------------------------
// branch_jump_detect
// Purely combinational classifier: flags any instruction whose successor
// executes in a branch delay slot (all branches, REGIMM branches, j, jal,
// jr, jalr). Shared between the IF/ID register and the decode stage.
// Ports:
//   i_instr         32-bit instruction word
//   o_isBranchJump  1 when the word is a branch or jump
// ---------------------------------------------------------------------------
module branch_jump_detect
    import if_id_reg_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_isBranchJump
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unusedFields;

    assign w_opcode = opcodeOf(i_instr);
    assign w_funct  = functOf(i_instr);

    // Register and immediate fields play no part in the classification
    assign w_unusedFields = ^i_instr[25:6];

    // SPECIAL needs the funct field to tell jr/jalr from ALU operations
    always_comb begin
        o_isBranchJump = 1'b0;
        case (w_opcode)
            OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                o_isBranchJump = 1'b1;
            OP_SPECIAL:
                o_isBranchJump = (w_funct == FN_JR) || (w_funct == FN_JALR);
            default:
                o_isBranchJump = 1'b0;
        endcase
    end

endmodule

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Fetch-to-decode pipeline register. Captures the fetch PC and the
// instruction-memory word for it, tags illegal fetch addresses with AdEL,
// marks branch-delay-slot instructions for CP0 and precomputes PC+8 for
// link instructions. Priority each clock: reset > flush > stall > load.
// Ports:
//   IFID_clk_i      clock, all updates on the rising edge
//   IFID_reset_n_i  synchronous active-low reset
//   IFID_pc_i       PC of the instruction being fetched
//   IFID_instr_i    instruction-memory data for IFID_pc_i
//   IFID_stall_i    hold the current contents
//   IFID_flush_i    replace the contents with a bubble (PC still captured)
//   IFID_instr_o    instruction in decode (0 for bubbles and AdEL fetches)
//   IFID_pc_o       PC of the decode instruction
//   IFID_pc8_o      IFID_pc_o + 8
//   IFID_exc_o      ExcCode of the decode instruction, 0 when none
//   IFID_bd_o       decode instruction sits in a branch delay slot
//   IFID_valid_o    decode holds a real instruction rather than a bubble
// ---------------------------------------------------------------------------
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] PC_RESET = if_id_reg_pkg::PC_RESET,
    parameter logic [31:0] IM_BASE  = if_id_reg_pkg::IM_BASE,
    parameter logic [31:0] IM_LIMIT = if_id_reg_pkg::IM_LIMIT,
    parameter logic [4:0]  EXC_ADEL = if_id_reg_pkg::EXC_ADEL
) (
    input  logic        IFID_clk_i,
    input  logic        IFID_reset_n_i,
    input  logic [31:0] IFID_pc_i,
    input  logic [31:0] IFID_instr_i,
    input  logic        IFID_stall_i,
    input  logic        IFID_flush_i,
    output logic [31:0] IFID_instr_o,
    output logic [31:0] IFID_pc_o,
    output logic [31:0] IFID_pc8_o,
    output logic [4:0]  IFID_exc_o,
    output logic        IFID_bd_o,
    output logic        IFID_valid_o
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc8;
    logic [4:0]  r_exc;
    logic        r_bd;
    logic        r_valid;

    logic        w_fetchFault;
    logic        w_prevIsBranchJump;
    logic [31:0] w_pcPlus8;

    // Misaligned or outside the instruction-memory window
    assign w_fetchFault = (IFID_pc_i[1:0] != 2'b00) ||
                          (IFID_pc_i < IM_BASE)     ||
                          (IFID_pc_i > IM_LIMIT);

    assign w_pcPlus8 = IFID_pc_i + PC_LINK_OFFSET;

    // Looks at the instruction currently held, which is the predecessor of
    // the one being loaded; AdEL fetches and bubbles hold 0, so they never
    // flag their successor.
    branch_jump_detect u_branchJumpDetect (
        .i_instr        (r_instr),
        .o_isBranchJump (w_prevIsBranchJump)
    );

    // A flushed bubble still records the fetch PC so CP0 has a meaningful
    // EPC if an interrupt is taken on it.
    always_ff @(posedge IFID_clk_i) begin
        if (!IFID_reset_n_i) begin
            r_instr <= 32'd0;
            r_pc    <= PC_RESET;
            r_pc8   <= PC_RESET + PC_LINK_OFFSET;
            r_exc   <= EXC_NONE;
            r_bd    <= 1'b0;
            r_valid <= 1'b0;
        end else if (IFID_flush_i) begin
            r_instr <= 32'd0;
            r_pc    <= IFID_pc_i;
            r_pc8   <= w_pcPlus8;
            r_exc   <= EXC_NONE;
            r_bd    <= 1'b0;
            r_valid <= 1'b0;
        end else if (!IFID_stall_i) begin
            r_pc    <= IFID_pc_i;
            r_pc8   <= w_pcPlus8;
            r_valid <= 1'b1;
            r_bd    <= r_valid & w_prevIsBranchJump;
            if (w_fetchFault) begin
                r_exc   <= EXC_ADEL;
                r_instr <= 32'd0;
            end else begin
                r_exc   <= EXC_NONE;
                r_instr <= IFID_instr_i;
            end
        end
    end

    assign IFID_instr_o = r_instr;
    assign IFID_pc_o    = r_pc;
    assign IFID_pc8_o   = r_pc8;
    assign IFID_exc_o   = r_exc;
    assign IFID_bd_o    = r_bd;
    assign IFID_valid_o = r_valid;

endmodule
